mio_bus_ctrl: RTL and testbench

// - Memory/IO bus controller directly downstream of the multi-cycle CPU.
// - Consumes CPU requests (cpu_mio, mem_w, addr_in, data_from_cpu) and returns read data plus a one-cycle mio_ready ack.
// - Routes each access to a synchronous word RAM, a GPIO (switch/LED) port, or a 32-bit timer.
// - Adds RAM read wait states so the CPU FSM stalls until data is valid.

---
 rtl/mio_defs.sv | 26 ++
 rtl/mio_timer.sv | 38 +++
 rtl/mio_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mio_defs.sv
// Shared definitions for the memory/IO bus controller: FSM states, IO offsets, region decode.
package mio_defs;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RAM_RD = 3'd1,
      RAM_WR = 3'd2,
      IO     = 3'd3,
      ACK    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OFF_GPIO  = 2'd0,
      OFF_TIMER = 2'd1,
      OFF_CTRL  = 2'd2,
      OFF_NONE  = 2'd3
   } io_off_t;

   localparam logic [3:0] IO_BASE_DEF = 4'hF;

   // True when the byte address falls in the IO region.
   function automatic logic is_io(input logic [31:0] addr, input logic [3:0] base);
      return addr[31:28] == base;
   endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with enable, CPU write port and sticky wrap flag.
module mio_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        val_wr,
   input  logic        ctrl_wr,
   input  logic [31:0] din,
   output logic [31:0] value,
   output logic        enable,
   output logic        irq
);

   logic wrap;

   // A CPU write to the counter suppresses that cycle's increment, so no wrap either.
   assign wrap = enable && !val_wr && (value == '1);

   // Counter: CPU write has priority over the increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       value <= '0;
      else if (val_wr)  value <= din;
      else if (enable)  value <= value + 32'd1;
   end

   // Enable bit from ctrl bit 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       enable <= 1'b0;
      else if (ctrl_wr) enable <= din[0];
   end

   // Sticky wrap flag; a wrap in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   irq <= 1'b0;
      else if (wrap)                irq <= 1'b1;
      else if (ctrl_wr && din[1])   irq <= 1'b0;
   end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU-facing memory/IO controller: routes word accesses to RAM, GPIO or timer and acks each one.
module mio_bus_ctrl
   import mio_defs::*;
#(
   parameter int unsigned RAM_AW  = 10,
   parameter int unsigned RAM_LAT = 1,
   parameter logic [3:0]  IO_BASE = IO_BASE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mio,
   input  logic              mem_w,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       data_from_cpu,
   output logic [31:0]       data_to_cpu,
   output logic              mio_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out,
   output logic              timer_irq
);

   localparam logic [2:0] LAT_INIT = 3'(RAM_LAT);

   state_t      state, state_next;
   logic [2:0]  wait_cnt, wait_next;
   logic        en_next, we_next, rdy_next;
   logic        cap_ram, cap_io;
   io_off_t     off;
   logic [31:0] io_rdata;
   logic        io_wr;
   logic        tmr_val_wr, tmr_ctrl_wr, tmr_en;
   logic [31:0] tmr_value;
   logic        unused_addr;

   assign off         = io_off_t'(addr_in[3:2]);
   assign ram_addr    = addr_in[RAM_AW+1:2];
   assign ram_din     = data_from_cpu;
   assign io_wr       = (state == IO) && mem_w;
   assign tmr_val_wr  = io_wr && (off == OFF_TIMER);
   assign tmr_ctrl_wr = io_wr && (off == OFF_CTRL);
   assign unused_addr = ^addr_in;

   mio_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .val_wr  (tmr_val_wr),
      .ctrl_wr (tmr_ctrl_wr),
      .din     (data_from_cpu),
      .value   (tmr_value),
      .enable  (tmr_en),
      .irq     (timer_irq)
   );

   // IO read mux by word offset.
   always_comb begin
      io_rdata = '0;
      case (off)
         OFF_GPIO:  io_rdata = {16'h0000, sw_in};
         OFF_TIMER: io_rdata = tmr_value;
         OFF_CTRL:  io_rdata = {30'b0, timer_irq, tmr_en};
         default:   io_rdata = '0;
      endcase
   end

   // Next state plus next values of the registered strobes (ram_en/ram_we/mio_ready).
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      en_next    = 1'b0;
      we_next    = 1'b0;
      rdy_next   = 1'b0;
      cap_ram    = 1'b0;
      cap_io     = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_mio) begin
               if (is_io(addr_in, IO_BASE)) begin
                  state_next = IO;
               end else if (mem_w) begin
                  state_next = RAM_WR;
                  en_next    = 1'b1;
                  we_next    = 1'b1;
               end else begin
                  state_next = RAM_RD;
                  en_next    = 1'b1;
                  wait_next  = LAT_INIT;
               end
            end
         end
         RAM_RD: begin
            if (wait_cnt == 3'd0) begin
               state_next = ACK;
               rdy_next   = 1'b1;
               cap_ram    = 1'b1;
            end else begin
               wait_next = wait_cnt - 3'd1;
            end
         end
         RAM_WR: begin
            state_next = ACK;
            rdy_next   = 1'b1;
         end
         IO: begin
            state_next = ACK;
            rdy_next   = 1'b1;
            cap_io     = !mem_w;
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State and wait-count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   // Strobes are registered so they align with the state they belong to; reset drops them at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         mio_ready   <= 1'b0;
         data_to_cpu <= '0;
         led_out     <= '0;
      end else begin
         ram_en    <= en_next;
         ram_we    <= we_next;
         mio_ready <= rdy_next;
         if (cap_ram)     data_to_cpu <= ram_dout;
         else if (cap_io) data_to_cpu <= io_rdata;
         if (io_wr && (off == OFF_GPIO)) led_out <= data_from_cpu[15:0];
      end
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: two instances (RAM latency 1 and 3), behavioural RAMs, scoreboard of acks.
module tb_mio_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        cpu_mio       [2];
   logic        mem_w         [2];
   logic [31:0] addr_in       [2];
   logic [31:0] data_from_cpu [2];
   logic [31:0] data_to_cpu   [2];
   logic        mio_ready     [2];
   logic        ram_en        [2];
   logic        ram_we        [2];
   logic [9:0]  ram_addr      [2];
   logic [31:0] ram_din       [2];
   logic [31:0] ram_dout      [2];
   logic [15:0] sw_in         [2];
   logic [15:0] led_out       [2];
   logic        timer_irq     [2];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      int          lat;
      bit          chk_data;
   } exp_t;
   exp_t sb[$];

   logic [7:0]  en_trace;
   int          we_cnt;
   logic [31:0] addr_c1;
   logic [31:0] saved;

   mio_bus_ctrl #(.RAM_AW(10), .RAM_LAT(1), .IO_BASE(4'hF)) u0 (
      .clk(clk), .reset(reset), .cpu_mio(cpu_mio[0]), .mem_w(mem_w[0]),
      .addr_in(addr_in[0]), .data_from_cpu(data_from_cpu[0]), .data_to_cpu(data_to_cpu[0]),
      .mio_ready(mio_ready[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
      .ram_din(ram_din[0]), .ram_dout(ram_dout[0]), .sw_in(sw_in[0]), .led_out(led_out[0]),
      .timer_irq(timer_irq[0])
   );

   mio_bus_ctrl #(.RAM_AW(10), .RAM_LAT(3), .IO_BASE(4'hF)) u1 (
      .clk(clk), .reset(reset), .cpu_mio(cpu_mio[1]), .mem_w(mem_w[1]),
      .addr_in(addr_in[1]), .data_from_cpu(data_from_cpu[1]), .data_to_cpu(data_to_cpu[1]),
      .mio_ready(mio_ready[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
      .ram_din(ram_din[1]), .ram_dout(ram_dout[1]), .sw_in(sw_in[1]), .led_out(led_out[1]),
      .timer_irq(timer_irq[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous RAMs: read data appears LAT cycles after the cycle ram_en is high.
   for (genvar g = 0; g < 2; g++) begin : g_ram
      logic [31:0] mem  [1024];
      logic [31:0] pipe [4];
      always @(posedge clk) begin
         if (ram_en[g]) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            pipe[0] <= mem[ram_addr[g]];
         end
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign ram_dout[g] = (g == 0) ? pipe[0] : pipe[2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One CPU access: push the expectation, drive, wait (bounded) for the ack, pop and compare.
   task automatic do_access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] ed, input int el, input bit drop_early);
      exp_t e;
      int   n;
      bit   got;
      e.data = ed; e.lat = el; e.chk_data = !w;
      sb.push_back(e);
      en_trace = '0; we_cnt = 0; addr_c1 = '0;
      @(negedge clk);
      cpu_mio[d] = 1'b1; mem_w[d] = w; addr_in[d] = a; data_from_cpu[d] = wd;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (n < 8) en_trace[n] = ram_en[d];
         if (ram_we[d]) we_cnt++;
         if (n == 1) addr_c1 = 32'(ram_addr[d]);
         if (drop_early && n == 1) cpu_mio[d] = 1'b0;
         if (mio_ready[d]) got = 1;
      end
      cpu_mio[d] = 1'b0;
      e = sb.pop_front();
      chk("ack_seen", 32'(got), 32'd1);
      chk("latency", 32'(n), 32'(e.lat));
      if (e.chk_data) chk("rdata", data_to_cpu[d], e.data);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   acks;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cpu_mio[d] = 0; mem_w[d] = 0; addr_in[d] = '0; data_from_cpu[d] = '0; sw_in[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready",  32'(mio_ready[0]), 32'd0);
      chk("rst_ram_en", 32'(ram_en[0]),    32'd0);
      chk("rst_data",   data_to_cpu[0],    32'd0);
      chk("rst_led",    32'(led_out[0]),   32'd0);
      chk("rst_irq",    32'(timer_irq[0]), 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // RAM write/read, latency 1
      do_access(0, 1, 32'h0000_0010, 32'h1234_5678, 32'h0, 2, 0);
      chk("wr_ram_addr", addr_c1, 32'd4);
      chk("wr_we_once", 32'(we_cnt), 32'd1);
      do_access(0, 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 0);
      do_access(0, 1, 32'h0000_0FFF, 32'h0BAD_F00D, 32'h0, 2, 0);
      chk("wr_top_addr", addr_c1, 32'h3FF);
      do_access(0, 0, 32'h0000_0FFC, 32'h0, 32'h0BAD_F00D, 3, 0);

      // RAM latency 3; second read drops cpu_mio after the first cycle
      do_access(1, 1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 2, 0);
      do_access(1, 0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 5, 0);
      chk("lat3_en_first_only", 32'(en_trace[4:1]), 32'h1);
      do_access(1, 0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 5, 1);

      // GPIO
      do_access(0, 1, 32'hF000_0000, 32'h0000_A5A5, 32'h0, 2, 0);
      chk("led_a5a5", 32'(led_out[0]), 32'h0000_A5A5);
      saved = data_to_cpu[0];
      chk("wr_keeps_data", data_to_cpu[0], 32'h0BAD_F00D);
      sw_in[0] = 16'h00FF;
      do_access(0, 0, 32'hF000_0000, 32'h0, 32'h0000_00FF, 2, 0);

      // Unmapped IO: reads 0, writes ignored but acked
      do_access(0, 0, 32'hF000_000C, 32'h0, 32'h0, 2, 0);
      do_access(0, 1, 32'hF000_000C, 32'h0000_1111, 32'h0, 2, 0);
      chk("unmapped_wr_led", 32'(led_out[0]), 32'h0000_A5A5);

      // Timer
      do_access(0, 1, 32'hF000_0004, 32'h0000_0100, 32'h0, 2, 0);
      do_access(0, 0, 32'hF000_0004, 32'h0, 32'h0000_0100, 2, 0);
      do_access(0, 1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0, 2, 0);
      do_access(0, 1, 32'hF000_0008, 32'h0000_0001, 32'h0, 2, 0);
      chk("irq_not_yet", 32'(timer_irq[0]), 32'd0);
      @(posedge clk); #1;
      chk("irq_on_wrap", 32'(timer_irq[0]), 32'd1);
      do_access(0, 0, 32'hF000_0008, 32'h0, 32'h0000_0003, 2, 0);
      do_access(0, 1, 32'hF000_0008, 32'h0000_0002, 32'h0, 2, 0);
      chk("irq_cleared", 32'(timer_irq[0]), 32'd0);
      do_access(0, 0, 32'hF000_0008, 32'h0, 32'h0, 2, 0);

      // Back-to-back: cpu_mio held high, three acks expected at cycles 2, 5, 8
      sw_in[0] = 16'h3C5A;
      for (int k = 0; k < 3; k++) begin
         e.data = 32'h0000_3C5A; e.lat = 2 + 3*k; e.chk_data = 1;
         sb.push_back(e);
      end
      @(negedge clk);
      cpu_mio[0] = 1'b1; mem_w[0] = 1'b0; addr_in[0] = 32'hF000_0000;
      acks = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (mio_ready[0]) begin
            acks++;
            if (acks == 3) cpu_mio[0] = 1'b0;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("b2b_ack_cycle", 32'(n), 32'(e.lat));
               chk("b2b_rdata", data_to_cpu[0], e.data);
            end
         end
      end
      chk("b2b_ack_count", 32'(acks), 32'd3);

      // Reset in the middle of a RAM read
      @(negedge clk);
      cpu_mio[1] = 1'b1; mem_w[1] = 1'b0; addr_in[1] = 32'h0000_0020;
      @(posedge clk); #1;
      chk("pre_rst_ram_en", 32'(ram_en[1]), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_ram_en", 32'(ram_en[1]),    32'd0);
      chk("mid_rst_data",   data_to_cpu[1],    32'd0);
      chk("mid_rst_led0",   32'(led_out[0]),   32'd0);
      chk("mid_rst_data0",  data_to_cpu[0],    32'd0);
      acks = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (mio_ready[1]) acks++;
      end
      cpu_mio[1] = 1'b0;
      @(negedge clk); reset = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (mio_ready[1]) acks++;
      end
      chk("no_ack_after_rst", 32'(acks), 32'd0);
      do_access(1, 1, 32'hF000_0000, 32'h0000_0042, 32'h0, 2, 0);
      chk("post_rst_led", 32'(led_out[1]), 32'h0000_0042);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
